// File: rtl/bcd_counter_ctrl.sv
// Run/pause/clear sequencer and two-digit display scanner for a 00-99 BCD counter.
// Buttons are synchronised and edge-detected; all outputs are registered.
module bcd_counter_ctrl #(
    parameter int TICK_DIV = 1000,
    parameter int SCAN_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       clr_btn,
    input  logic       at_max,
    input  logic [6:0] seg_lo,
    input  logic [6:0] seg_hi,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [6:0] seg,
    output logic [1:0] dig_sel,
    output logic       running,
    output logic [1:0] state_dbg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCAN_ONE   = SW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] presc, presc_next;
    logic          en_next, clr_next;
    logic [2:0]    sync1, sync2, btn_prev, btn_rise;
    logic          evt_start, evt_stop, evt_clr, tick;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    dig_next;

    // Bit order {clr, stop, start}; btn_rise is registered so a press acts three edges after first sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            btn_prev <= '0;
            btn_rise <= '0;
        end else begin
            sync1    <= {clr_btn, stop_btn, start_btn};
            sync2    <= sync1;
            btn_prev <= sync2;
            btn_rise <= sync2 & ~btn_prev;
        end
    end

    // Only the highest-priority event of a cycle survives, even if the state then ignores it.
    assign evt_clr   = btn_rise[2];
    assign evt_stop  = btn_rise[1] & ~btn_rise[2];
    assign evt_start = btn_rise[0] & ~btn_rise[1] & ~btn_rise[2];
    assign tick      = (presc == PRESC_LAST);

    always_comb begin
        state_next = state;
        presc_next = presc;
        en_next    = 1'b0;
        clr_next   = 1'b0;
        case (state)
            IDLE, PAUSE: begin
                if (evt_clr) begin
                    state_next = IDLE;
                    clr_next   = 1'b1;
                end else if (evt_start) begin
                    state_next = RUN;
                    presc_next = '0;
                end
            end
            RUN: begin
                if (evt_clr) begin
                    state_next = IDLE;
                    clr_next   = 1'b1;
                    presc_next = '0;
                end else if (evt_stop) begin
                    state_next = PAUSE;
                end else begin
                    presc_next = tick ? '0 : presc + PRESC_ONE;
                    if (tick) begin
                        if (at_max) state_next = DONE;
                        else        en_next    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (evt_clr) begin
                    state_next = IDLE;
                    clr_next   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            presc   <= '0;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            presc   <= presc_next;
            cnt_en  <= en_next;
            cnt_clr <= clr_next;
            running <= (state_next == RUN);
        end
    end

    assign state_dbg = state;

    // seg follows the digit that will be selected after this edge, so bus and enable always agree.
    assign dig_next = (scan_cnt == SCAN_LAST) ? {dig_sel[0], dig_sel[1]} : dig_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            dig_sel  <= 2'b01;
            seg      <= 7'b0000000;
        end else begin
            scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SCAN_ONE;
            dig_sel  <= dig_next;
            seg      <= (dig_next == 2'b01) ? seg_lo : seg_hi;
        end
    end

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Randomised scoreboard bench for bcd_counter_ctrl with an attached 00-99 counter model.
module tb_bcd_counter_ctrl;

    localparam int TD = 4;
    localparam int SD = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    localparam logic [11:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 2'b01, 7'b0000000};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_btn = 1'b0, stop_btn = 1'b0, clr_btn = 1'b0;
    logic       at_max;
    logic [6:0] seg_lo, seg_hi, seg;
    logic       cnt_en, cnt_clr, running;
    logic [1:0] dig_sel, state_dbg;
    logic       ovr = 1'b1;
    int         count;

    int n_cmp  = 0;
    int n_fail = 0;
    int clr_seen = 0;
    logic [11:0] exp_q[$];

    bcd_counter_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
        .clr_btn(clr_btn), .at_max(at_max), .seg_lo(seg_lo), .seg_hi(seg_hi),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .seg(seg), .dig_sel(dig_sel),
        .running(running), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input int d);
        case (d)
            0: return 7'b0111111; 1: return 7'b0000110; 2: return 7'b1011011;
            3: return 7'b1001111; 4: return 7'b1100110; 5: return 7'b1101101;
            6: return 7'b1111101; 7: return 7'b0000111; 8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    // Behavioural 00-99 counter driven by the controller's strobes.
    always @(posedge clk or negedge rst) begin
        if (!rst)         count <= 0;
        else if (cnt_clr) count <= 0;
        else if (cnt_en)  count <= (count == 99) ? 0 : count + 1;
    end
    assign at_max = (count == 99);
    assign seg_lo = ovr ? 7'b0111111 : dec7(count % 10);
    assign seg_hi = ovr ? 7'b0000110 : dec7(count / 10);

    // Reference model: per edge, derive the expected registered outputs and queue them.
    initial begin
        int   mode, edge_no, entry, ev;
        bit   hs[5], hp[5], hc[5];
        logic e_en, e_clr;
        logic [1:0] e_dig;
        logic [6:0] e_seg;
        mode = M_IDLE; edge_no = 0; entry = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                mode = M_IDLE; edge_no = 0; entry = 0;
                for (int i = 0; i < 5; i++) begin hs[i] = 0; hp[i] = 0; hc[i] = 0; end
            end else begin
                edge_no++;
                for (int i = 4; i > 0; i--) begin hs[i] = hs[i-1]; hp[i] = hp[i-1]; hc[i] = hc[i-1]; end
                hs[0] = start_btn; hp[0] = stop_btn; hc[0] = clr_btn;
                // A press first seen at edge k acts at edge k+3; one event per cycle by priority.
                ev = (hc[3] && !hc[4]) ? 3 : (hp[3] && !hp[4]) ? 2 : (hs[3] && !hs[4]) ? 1 : 0;
                e_en = 1'b0; e_clr = 1'b0;
                if (ev == 3) begin
                    mode = M_IDLE; e_clr = 1'b1;
                end else if (ev == 2 && mode == M_RUN) begin
                    mode = M_PAUSE;
                end else if (ev == 1 && (mode == M_IDLE || mode == M_PAUSE)) begin
                    mode = M_RUN; entry = edge_no;
                end else if (mode == M_RUN && ((edge_no - entry) % TD == 0)) begin
                    if (at_max) mode = M_DONE;
                    else        e_en = 1'b1;
                end
                e_dig = ((edge_no / SD) % 2 == 0) ? 2'b01 : 2'b10;
                e_seg = (e_dig == 2'b01) ? seg_lo : seg_hi;
                exp_q.push_back({e_en, e_clr, (mode == M_RUN), e_dig, e_seg});
            end
        end
    end

    // Monitor: compare every registered output cycle against the queued expectation.
    initial begin
        logic [11:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (rst && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {cnt_en, cnt_clr, running, dig_sel, seg};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL out_cycle t=%0t: got en=%b clr=%b run=%b dig=%b seg=%b, expected en=%b clr=%b run=%b dig=%b seg=%b",
                             $time, act_v[11], act_v[10], act_v[9], act_v[8:7], act_v[6:0],
                             exp_v[11], exp_v[10], exp_v[9], exp_v[8:7], exp_v[6:0]);
                end
                if (cnt_clr) clr_seen++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which, input int hold);
        if (which == 0) start_btn = 1'b1;
        if (which == 1) stop_btn  = 1'b1;
        if (which == 2) clr_btn   = 1'b1;
        tick_n(hold);
        start_btn = 1'b0; stop_btn = 1'b0; clr_btn = 1'b0;
    endtask

    task automatic wait_en(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cnt_en) break;
        end
        if (i == budget) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_count(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (count == target) break;
        end
        if (i == budget) check("wait_count_timeout", count, target);
    endtask

    initial begin
        int gap, clr_before;
        // Reset state, then a scan window with fixed digit patterns.
        tick_n(2);
        check("reset_outputs", {cnt_en, cnt_clr, running, dig_sel, seg}, RESET_VEC);
        #1 rst = 1'b1;
        tick_n(12);
        ovr = 1'b0;

        // Start and run for five advances; stop lands on the sixth tick.
        press(0, 2);
        for (int k = 0; k < 5; k++) wait_en("run_en", 40);
        stop_btn = 1'b1;
        tick_n(3);
        stop_btn = 1'b0;
        tick_n(6);
        check("count_after_5", count, 5);
        check("paused_running", running, 0);

        // Resume: first advance exactly TD cycles after RUN is entered.
        press(0, 1);
        for (gap = 0; gap < 20 && !running; gap++) @(negedge clk);
        gap = 0;
        do begin @(negedge clk); gap++; end while (!cnt_en && gap < 20);
        check("resume_first_en_gap", gap, TD);

        // All three buttons together in RUN; clr is held long.
        tick_n(2);
        clr_before = clr_seen;
        start_btn = 1'b1; stop_btn = 1'b1; clr_btn = 1'b1;
        tick_n(10);
        start_btn = 1'b0; stop_btn = 1'b0; clr_btn = 1'b0;
        tick_n(4);
        check("clr_single_pulse", clr_seen - clr_before, 1);
        check("count_cleared", count, 0);
        check("idle_running", running, 0);

        // Run up to 99 and stop there.
        press(0, 3);
        wait_count(99, 600);
        tick_n(3 * TD);
        check("done_count_99", count, 99);
        check("done_running", running, 0);
        press(0, 2);
        tick_n(3 * TD);
        check("done_ignores_start", running, 0);
        check("done_count_hold", count, 99);
        press(2, 2);
        tick_n(4);
        check("done_cleared", count, 0);

        // Asynchronous reset while an advance strobe is high.
        press(0, 1);
        wait_en("pre_reset_en", 40);
        #1 rst = 1'b0;
        #1 check("reset_mid_strobe", {cnt_en, cnt_clr, running, dig_sel, seg}, RESET_VEC);
        exp_q.delete();
        tick_n(2);
        #1 rst = 1'b1;
        tick_n(10);
        check("post_reset_count", count, 0);

        // Random button activity.
        for (int k = 0; k < 120; k++) begin
            start_btn = ($urandom_range(0, 2) == 0);
            stop_btn  = ($urandom_range(0, 4) == 0);
            clr_btn   = ($urandom_range(0, 7) == 0);
            tick_n($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 0) begin
                start_btn = 1'b0; stop_btn = 1'b0; clr_btn = 1'b0;
                tick_n($urandom_range(1, 30));
            end
        end
        start_btn = 1'b0; stop_btn = 1'b0; clr_btn = 1'b0;
        tick_n(10);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
